// File: rtl/uc_mc.sv
// Multicycle control unit: decodes the IR and sequences fetch/decode/execute/memory/write-back.
// Define UC_MEM_WAIT_EN to stall memory states on mem_ready with a timeout trap.
module uc_mc #(
  parameter int ALUF_W      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       instruction,
  input  logic              zero,
  input  logic              lt,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic [1:0]        BranchOp,
  output logic              PCSrc,
  output logic [ALUF_W-1:0] ALUFunct,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic              LoadRegA,
  output logic              LoadRegB,
  output logic              LoadALUOut,
  output logic              LoadMDR,
  output logic              LoadIR,
  output logic              DMemWr,
  output logic              DMemRd,
  output logic              IMemRd,
  output logic [1:0]        MemToReg,
  output logic              WriteReg,
  output logic              illegal,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_READ = 4'd5,
    S_MEM_WRITE= 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_LUI      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [2:0] F_IDLE = 3'd0;
  localparam logic [2:0] F_ADD  = 3'd1;
  localparam logic [2:0] F_SUB  = 3'd2;
  localparam logic [2:0] F_AND  = 3'd3;
  localparam logic [2:0] F_OR   = 3'd4;
  localparam logic [2:0] F_SLT  = 3'd5;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [2:0] alu_f;
  logic [2:0] r_alu;
  logic       br_ok;
  logic       mem_done;
  logic       tmo;
  logic       unused_sig;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];

`ifdef UC_MEM_WAIT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mem_done   = mem_ready;
  assign tmo        = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign unused_sig = ^{zero, lt, instruction[31], instruction[29:15], instruction[11:7]};

  // Saturating wait counter, cleared whenever the state changes.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (!mem_ready && cnt_q != CNT_W'(MEM_TIMEOUT)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = MEM_TIMEOUT;
  assign mem_done   = 1'b1;
  assign tmo        = 1'b0;
  assign unused_sig = ^{zero, lt, mem_ready, instruction[31], instruction[29:15], instruction[11:7]};
`endif

  always_comb begin
    r_alu = F_IDLE;
    case ({funct7_5, funct3})
      4'b0000: r_alu = F_ADD;
      4'b1000: r_alu = F_SUB;
      4'b0111: r_alu = F_AND;
      4'b0110: r_alu = F_OR;
      4'b0010: r_alu = F_SLT;
      default: r_alu = F_IDLE;
    endcase
  end

  assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchOp    = 2'b00;
    PCSrc       = 1'b0;
    alu_f       = F_IDLE;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    LoadALUOut  = 1'b0;
    LoadMDR     = 1'b0;
    LoadIR      = 1'b0;
    DMemWr      = 1'b0;
    DMemRd      = 1'b0;
    IMemRd      = 1'b0;
    MemToReg    = 2'b00;
    WriteReg    = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        IMemRd  = 1'b1;
        ALUSrcB = 2'b01;
        alu_f   = F_ADD;
        if (mem_done) begin
          LoadIR  = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          state_d = S_ILLEGAL;
        end
      end
      S_DECODE: begin
        LoadRegA   = 1'b1;
        LoadRegB   = 1'b1;
        ALUSrcB    = 2'b11;
        alu_f      = F_ADD;
        LoadALUOut = 1'b1;
        case (opcode)
          7'b0110011:             state_d = S_EXEC_R;
          7'b0010011:             state_d = S_EXEC_I;
          7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
          7'b1100011:             state_d = S_BRANCH;
          7'b0110111:             state_d = S_LUI;
          7'b1101111:             state_d = S_JAL;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        if (r_alu != F_IDLE) begin
          alu_f      = r_alu;
          LoadALUOut = 1'b1;
          state_d    = S_WB_ALU;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (funct3 == 3'b000) begin
          alu_f      = F_ADD;
          LoadALUOut = 1'b1;
          state_d    = S_WB_ALU;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (funct3 == 3'b011) begin
          alu_f      = F_ADD;
          LoadALUOut = 1'b1;
          // opcode bit 5 separates store (0100011) from load (0000011)
          state_d    = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_MEM_READ: begin
        DMemRd = 1'b1;
        if (mem_done) begin
          LoadMDR = 1'b1;
          state_d = S_WB_MEM;
        end else if (tmo) begin
          state_d = S_ILLEGAL;
        end
      end
      S_MEM_WRITE: begin
        if (mem_done) begin
          DMemWr  = 1'b1;
          state_d = S_FETCH;
        end else if (tmo) begin
          state_d = S_ILLEGAL;
        end
      end
      S_WB_ALU: begin
        WriteReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_WB_MEM: begin
        WriteReg = 1'b1;
        MemToReg = 2'b01;
        state_d  = S_FETCH;
      end
      S_LUI: begin
        WriteReg = 1'b1;
        MemToReg = 2'b10;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        alu_f    = F_SUB;
        PCSrc    = 1'b1;
        BranchOp = {funct3[2], funct3[0]};
        if (br_ok) begin
          PCWriteCond = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSrc    = 1'b1;
        WriteReg = 1'b1;
        MemToReg = 2'b11;
        state_d  = S_FETCH;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   state_d = S_FETCH;
    endcase
    // While reset is held only the fetch request stays up.
    if (!reset_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchOp    = 2'b00;
      PCSrc       = 1'b0;
      alu_f       = F_IDLE;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      LoadRegA    = 1'b0;
      LoadRegB    = 1'b0;
      LoadALUOut  = 1'b0;
      LoadMDR     = 1'b0;
      LoadIR      = 1'b0;
      DMemWr      = 1'b0;
      DMemRd      = 1'b0;
      IMemRd      = 1'b1;
      MemToReg    = 2'b00;
      WriteReg    = 1'b0;
      illegal     = 1'b0;
    end
  end

  assign ALUFunct = ALUF_W'(alu_f);
  assign state    = state_q;

endmodule

// File: tb/tb_uc_mc.sv
// Bench for uc_mc: directed scenarios plus random instructions checked against a path-level model.
`timescale 1ns/1ps
module tb_uc_mc;
  localparam int ALUF_W      = 4;
  localparam int MEM_TIMEOUT = 15;
`ifdef UC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [31:0]       instruction = 32'd0;
  logic              zero = 1'b0, lt = 1'b0, mem_ready = 1'b1;
  logic              PCWrite, PCWriteCond, PCSrc, ALUSrcA;
  logic [1:0]        BranchOp, ALUSrcB, MemToReg;
  logic [ALUF_W-1:0] ALUFunct;
  logic              LoadRegA, LoadRegB, LoadALUOut, LoadMDR, LoadIR;
  logic              DMemWr, DMemRd, IMemRd, WriteReg, illegal;
  logic [3:0]        state;

  uc_mc #(.ALUF_W(ALUF_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchOp(BranchOp),
    .PCSrc(PCSrc), .ALUFunct(ALUFunct), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .LoadALUOut(LoadALUOut), .LoadMDR(LoadMDR),
    .LoadIR(LoadIR), .DMemWr(DMemWr), .DMemRd(DMemRd), .IMemRd(IMemRd), .MemToReg(MemToReg),
    .WriteReg(WriteReg), .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int path[$];
  int mdr_cnt = 0, dwr_cnt = 0, wr_cnt = 0, pcw_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every output except IMemRd, illegal and state.
  function automatic logic [31:0] others();
    return 32'({PCWrite, PCWriteCond, BranchOp, PCSrc, ALUFunct, ALUSrcA, ALUSrcB, LoadRegA,
                LoadRegB, LoadALUOut, LoadMDR, LoadIR, DMemWr, DMemRd, MemToReg, WriteReg});
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic b);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = op;
    r[14:12] = f3;
    r[30] = b;
    return r;
  endfunction

  function automatic int r_alu(input logic b, input logic [2:0] f3);
    case ({b, f3})
      4'b0000: return 1;
      4'b1000: return 2;
      4'b0111: return 3;
      4'b0110: return 4;
      4'b0010: return 5;
      default: return 0;
    endcase
  endfunction

  // State path of one instruction, from the decode rules.
  task automatic build_path(input logic [31:0] ins, output bit legal);
    logic [2:0] f3;
    f3 = ins[14:12];
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (ins[6:0])
      7'b0110011: begin path.push_back(2); path.push_back(r_alu(ins[30], f3) != 0 ? 7 : 12); end
      7'b0010011: begin path.push_back(3); path.push_back(f3 == 3'd0 ? 7 : 12); end
      7'b0000011: begin
        path.push_back(4);
        if (f3 == 3'd3) begin path.push_back(5); path.push_back(8); end
        else path.push_back(12);
      end
      7'b0100011: begin path.push_back(4); path.push_back(f3 == 3'd3 ? 6 : 12); end
      7'b1100011: begin path.push_back(10); if (!(f3 inside {3'd0, 3'd1, 3'd4, 3'd5})) path.push_back(12); end
      7'b0110111: path.push_back(9);
      7'b1101111: path.push_back(11);
      default:    path.push_back(12);
    endcase
    legal = (path[path.size()-1] != 12);
  endtask

  task automatic check_state(input int st, input logic [31:0] ins, input bit legal, input bit done);
    int ea, eb;
    logic [2:0] f3;
    f3 = ins[14:12];
    mdr_cnt += int'(LoadMDR); dwr_cnt += int'(DMemWr); wr_cnt += int'(WriteReg); pcw_cnt += int'(PCWrite);
    chk("state", 32'(state), 32'(st));
    chk("IMemRd", 32'(IMemRd), 32'(st == 0));
    chk("LoadIR", 32'(LoadIR), 32'(st == 0 && done));
    chk("PCWrite", 32'(PCWrite), 32'((st == 0 && done) || st == 11));
    chk("LoadMDR", 32'(LoadMDR), 32'(st == 5 && done));
    chk("DMemRd", 32'(DMemRd), 32'(st == 5));
    chk("DMemWr", 32'(DMemWr), 32'(st == 6 && done));
    chk("WriteReg", 32'(WriteReg), 32'(st inside {7, 8, 9, 11}));
    chk("PCWriteCond", 32'(PCWriteCond), 32'(st == 10 && legal));
    chk("illegal", 32'(illegal), 32'd0);
    chk("LoadRegAB", 32'({LoadRegA, LoadRegB}), (st == 1) ? 32'd3 : 32'd0);
    if (st inside {7, 8, 9, 11})
      chk("MemToReg", 32'(MemToReg), (st == 7) ? 32'd0 : (st == 8) ? 32'd1 : (st == 9) ? 32'd2 : 32'd3);
    if (st inside {10, 11}) chk("PCSrc_target", 32'(PCSrc), 32'd1);
    if (st == 0 && done) chk("PCSrc_fetch", 32'(PCSrc), 32'd0);
    if (legal || st inside {0, 1}) begin
      ea = (st == 2) ? r_alu(ins[30], f3) : (st == 10) ? 2 : (st inside {0, 1, 3, 4}) ? 1 : 0;
      chk("ALUFunct", 32'(ALUFunct), 32'(ea));
      if (st inside {0, 1, 2, 3, 4, 10}) begin
        eb = (st == 0) ? 1 : (st == 1) ? 3 : (st inside {3, 4}) ? 2 : 0;
        chk("ALUSrcB", 32'(ALUSrcB), 32'(eb));
        chk("ALUSrcA", 32'(ALUSrcA), 32'(st inside {2, 3, 4, 10}));
      end
      chk("LoadALUOut", 32'(LoadALUOut), 32'(st inside {1, 2, 3, 4}));
    end
    if (legal && st == 10) chk("BranchOp", 32'(BranchOp), 32'({f3[2], f3[0]}));
  endtask

  task automatic check_trap(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clock);
      instruction = $urandom;
      mem_ready = 1'($urandom);
      #1;
      wr_cnt += int'(WriteReg); pcw_cnt += int'(PCWrite); dwr_cnt += int'(DMemWr);
      chk("trap_state", 32'(state), 32'd12);
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_outputs", others(), 32'd0);
      chk("trap_imemrd", 32'(IMemRd), 32'd0);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, output bit trapped);
    bit legal, done, tmo;
    int st, waits, k;
    build_path(ins, legal);
    trapped = 0;
    tmo = 0;
    for (int i = 0; i < path.size() && !trapped; i++) begin
      st = path[i];
      if (st == 12) begin
        check_trap(3);
        trapped = 1;
      end else begin
        waits = (st == 0) ? wf : ((st == 5 || st == 6) ? wm : 0);
        k = 0;
        done = 0;
        while (!done && !tmo) begin
          @(negedge clock);
          instruction = (st == 0) ? $urandom : ins;
          mem_ready = (st inside {0, 5, 6}) ? (k >= waits) : 1'($urandom);
          zero = 1'($urandom);
          lt = 1'($urandom);
          done = !WAIT_EN || !(st inside {0, 5, 6}) || mem_ready;
          #1;
          check_state(st, ins, legal, done);
          if (!done) begin
            k++;
            tmo = (k == MEM_TIMEOUT);
          end
        end
        if (tmo) begin
          check_trap(3);
          trapped = 1;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_imemrd"}, 32'(IMemRd), 32'd1);
    chk({tag, "_outputs"}, others(), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst");
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic step(input logic [31:0] ins, input logic rdy);
    @(negedge clock);
    instruction = ins;
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    bit tr;
    logic [31:0] ins, ld;
    logic [6:0] ops [8];
    int wf, wm;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111, 7'b0000000};

    #2 check_reset_outputs("por");
    @(posedge clock);
    #1 reset_n = 1'b1;

    run_instr(32'h002081B3, 0, 0, tr);
    run_instr(mk(7'b1100011, 3'b000, 1'b0), 0, 0, tr);
    run_instr(mk(7'b1100011, 3'b001, 1'b0), 0, 0, tr);
    run_instr(mk(7'b0010011, 3'b000, 1'b0), 1, 0, tr);
    run_instr(mk(7'b0110111, 3'b101, 1'b1), 0, 0, tr);
    run_instr(mk(7'b1101111, 3'b010, 1'b0), 0, 0, tr);
    run_instr(mk(7'b0110011, 3'b111, 1'b0), 0, 0, tr);

    mdr_cnt = 0;
    run_instr(mk(7'b0000011, 3'b011, 1'b0), 0, 3, tr);
    chk("ld_mdr_pulses", 32'(mdr_cnt), 32'd1);

    dwr_cnt = 0;
    run_instr(mk(7'b0100011, 3'b011, 1'b0), 0, MEM_TIMEOUT, tr);
    chk("sd_dmemwr_pulses", 32'(dwr_cnt), WAIT_EN ? 32'd0 : 32'd1);
    if (tr) check_trap(10);
    do_reset();

    wr_cnt = 0; pcw_cnt = 0;
    run_instr(mk(7'b1111111, 3'b000, 1'b0), 0, 0, tr);
    chk("op7f_writes", 32'(wr_cnt + pcw_cnt), 32'd1);
    do_reset();
    wr_cnt = 0; pcw_cnt = 0;
    run_instr(mk(7'b0110011, 3'b001, 1'b1), 0, 0, tr);
    chk("subf3_writes", 32'(wr_cnt + pcw_cnt), 32'd1);
    do_reset();

    ld = mk(7'b0000011, 3'b011, 1'b0);
    step(ld, 1'b1); chk("wbm_s0", 32'(state), 32'd0);
    step(ld, 1'b1); chk("wbm_s1", 32'(state), 32'd1);
    step(ld, 1'b1); chk("wbm_s4", 32'(state), 32'd4);
    step(ld, 1'b1); chk("wbm_s5", 32'(state), 32'd5);
    step(ld, 1'b1); chk("wbm_s8", 32'(state), 32'd8);
    chk("wbm_writereg", 32'(WriteReg), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("wbm_rst_writereg", 32'(WriteReg), 32'd0);
    check_reset_outputs("wbm_rst");
    @(posedge clock);
    #1 reset_n = 1'b1;
    run_instr(32'h002081B3, 0, 0, tr);

    for (int n = 0; n < 150; n++) begin
      ins = mk(ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom));
      if (ins[6:0] == 7'b0000000) ins[6:0] = 7'($urandom);
      wf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      wm = ($urandom_range(0, 19) == 0) ? MEM_TIMEOUT + 1 : int'($urandom_range(0, 3));
      run_instr(ins, wf, wm, tr);
      if (tr) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
